// File: rtl/add_tree_pkg.sv
// Shared types and width helper for the adder tree and its mean normaliser.
`timescale 1ns/1ps
package add_tree_pkg;

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} add_tree_mean_state_t;

  // Width of a sum of INPUTS words of WIDTH bits; the tree and the normaliser must agree.
  function automatic int add_tree_sum_width(input int width, input int inputs);
    return width + $clog2(inputs);
  endfunction

endpackage

// File: rtl/add_tree_mean_div.sv
// Restoring divider by the constant INPUTS, one quotient bit per clock, MSB first.
`timescale 1ns/1ps
module add_tree_mean_div #(
  parameter int SW     = 11,
  parameter int INPUTS = 5,
  parameter int RW     = $clog2(INPUTS) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [SW-1:0] magnitude,
  output logic          done,
  output logic [SW-1:0] quotient,
  output logic [RW-1:0] remainder
);

  localparam int CW = (SW > 1) ? $clog2(SW) : 1;
  localparam logic [RW:0] K = (RW+1)'(INPUTS);

  logic [SW-1:0] mag_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [RW:0]   trial;
  logic          take;

  // One extra bit so the shifted partial remainder never overflows, even for INPUTS=1.
  assign trial = {remainder, mag_q[cnt_q]};
  assign take  = trial >= K;
  assign done  = busy_q && (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      mag_q     <= magnitude;
      cnt_q     <= CW'(SW - 1);
      busy_q    <= 1'b1;
      quotient  <= '0;
      remainder <= '0;
    end else if (busy_q) begin
      remainder <= take ? RW'(trial - K) : trial[RW-1:0];
      quotient  <= (quotient << 1) | SW'(take);
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/add_tree_mean.sv
// Sequential mean of an adder-tree sum: sum / INPUTS, rounded half away from zero.
`timescale 1ns/1ps
module add_tree_mean
  import add_tree_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int INPUTS = 5,
  parameter int SW     = add_tree_sum_width(WIDTH, INPUTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_signed,
  input  logic [SW-1:0]    i_data,
  input  logic             i_valid,
  output logic             i_ready,
  output logic             o_signed,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             o_ready
);

  localparam int RW = $clog2(INPUTS) + 1;
  localparam logic [RW:0] K = (RW+1)'(INPUTS);

  add_tree_mean_state_t state_q, state_d;

  logic          start, neg_in, neg_q, div_done, round_up;
  logic [SW-1:0] mag, div_q, q_rnd;
  logic [RW-1:0] div_rem;

  assign i_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign start   = i_ready & i_valid;
  assign neg_in  = i_signed & i_data[SW-1];
  // Negation mod 2^SW keeps the most negative sum exact as an unsigned magnitude.
  assign mag     = neg_in ? (-i_data) : i_data;

  add_tree_mean_div #(.SW(SW), .INPUTS(INPUTS), .RW(RW)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .magnitude (mag),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_rem)
  );

  assign round_up = {div_rem, 1'b0} >= K;
  assign q_rnd    = div_q + SW'(round_up);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid)  state_d = DIV;
      DIV:     if (div_done) state_d = ROUND;
      ROUND:                 state_d = DONE;
      DONE:    if (o_ready)  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      neg_q    <= 1'b0;
      o_signed <= 1'b0;
      o_data   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        o_signed <= i_signed;
        neg_q    <= neg_in;
      end
      // Rounding on the magnitude then negating gives half-away-from-zero for both signs.
      if (state_q == ROUND)
        o_data <= neg_q ? WIDTH'(-q_rnd) : WIDTH'(q_rnd);
    end
  end

endmodule

// File: tb/tb_add_tree_mean.sv
// Directed bench for add_tree_mean with INPUTS=5 (SW=11) and INPUTS=4 (SW=10).
`timescale 1ns/1ps
module tb_add_tree_mean;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total = 0;

  logic        s5, v5, ir5, os5, ov5, or5;
  logic [10:0] d5;
  logic [7:0]  od5;
  logic        s4, v4, ir4, os4, ov4, or4;
  logic [9:0]  d4;
  logic [7:0]  od4;

  add_tree_mean #(.WIDTH(8), .INPUTS(5)) u5 (
    .clk(clk), .reset(reset), .i_signed(s5), .i_data(d5), .i_valid(v5), .i_ready(ir5),
    .o_signed(os5), .o_data(od5), .o_valid(ov5), .o_ready(or5));

  add_tree_mean #(.WIDTH(8), .INPUTS(4)) u4 (
    .clk(clk), .reset(reset), .i_signed(s4), .i_data(d4), .i_valid(v4), .i_ready(ir4),
    .o_signed(os4), .o_data(od4), .o_valid(ov4), .o_ready(or4));

  // Drivers: entered #1 after a rising edge with the DUT idle; lat counts edges from accept to o_valid.
  task automatic run5(input logic s, input logic [10:0] d, output logic [7:0] r, output int lat);
    r = '0;
    lat = -1;
    if (!ir5) return;
    s5 = s; d5 = d; v5 = 1'b1;
    @(posedge clk); #1 v5 = 1'b0; lat = 1;
    while (!ov5 && lat < 200) begin @(posedge clk); #1 lat++; end
    r = od5;
    @(posedge clk); #1;
  endtask

  task automatic run4(input logic s, input logic [9:0] d, output logic [7:0] r, output int lat);
    r = '0;
    lat = -1;
    if (!ir4) return;
    s4 = s; d4 = d; v4 = 1'b1;
    @(posedge clk); #1 v4 = 1'b0; lat = 1;
    while (!ov4 && lat < 200) begin @(posedge clk); #1 lat++; end
    r = od4;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [7:0] r;
    int lat;
    #12;
    total++; if (ov5 !== 1'b0) $display("FAIL reset_o_valid got %b want 0", ov5); else pass_cnt++;
    total++; if (od5 !== 8'h00) $display("FAIL reset_o_data got %h want 00", od5); else pass_cnt++;
    total++; if (ir5 !== 1'b1) $display("FAIL reset_i_ready got %b want 1", ir5); else pass_cnt++;
    total++; if ({os5, ov4, ir4} !== 3'b001) $display("FAIL reset_misc got %b want 001", {os5, ov4, ir4}); else pass_cnt++;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    run5(1'b0, 11'd12, r, lat);
    total++; if (r !== 8'd2) $display("FAIL first_result got %0d want 2", r); else pass_cnt++;
    total++; if (lat !== 13) $display("FAIL first_latency got %0d want 13", lat); else pass_cnt++;
  endtask

  task automatic test_rounding();
    logic [10:0] dv5 [0:6];
    logic        sg5 [0:6];
    logic [7:0]  ex5 [0:6];
    logic [9:0]  dv4 [0:3];
    logic        sg4 [0:3];
    logic [7:0]  ex4 [0:3];
    logic [7:0]  r;
    int lat;
    dv5 = '{11'd13, 11'd1275, 11'd0, 11'h580, 11'h27B, 11'h7FD, 11'h7FE};
    sg5 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ex5 = '{8'd3, 8'd255, 8'd0, 8'h80, 8'd127, 8'hFF, 8'h00};
    dv4 = '{10'd10, 10'd9, 10'h3F6, 10'h3F7};
    sg4 = '{1'b0, 1'b0, 1'b1, 1'b1};
    ex4 = '{8'd3, 8'd2, 8'hFD, 8'hFE};
    for (int i = 0; i < 7; i++) begin
      run5(sg5[i], dv5[i], r, lat);
      total++;
      if (r !== ex5[i]) $display("FAIL round5_%0d in %h got %h want %h", i, dv5[i], r, ex5[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      run4(sg4[i], dv4[i], r, lat);
      total++;
      if (r !== ex4[i]) $display("FAIL round4_%0d in %h got %h want %h", i, dv4[i], r, ex4[i]);
      else pass_cnt++;
    end
    total++; if (lat !== 12) $display("FAIL latency4 got %0d want 12", lat); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    or5 = 1'b0; s5 = 1'b0; d5 = 11'd12; v5 = 1'b1;
    @(posedge clk); #1 d5 = 11'd1275;
    n = 0;
    while (!ov5 && n < 200) begin @(posedge clk); #1 n++; end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (od5 !== 8'd2 || ir5 !== 1'b0 || ov5 !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    total++; if (bad != 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad); else pass_cnt++;
    or5 = 1'b1;
    @(posedge clk); #1;
    total++; if ({ir5, ov5} !== 2'b10) $display("FAIL bp_release got %b want 10", {ir5, ov5}); else pass_cnt++;
    @(posedge clk); #1 v5 = 1'b0;
    total++; if (ir5 !== 1'b0) $display("FAIL bp_next_accept got i_ready %b want 0", ir5); else pass_cnt++;
    n = 0;
    while (!ov5 && n < 200) begin @(posedge clk); #1 n++; end
    total++; if (od5 !== 8'd255) $display("FAIL bp_second_word got %0d want 255", od5); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_input_change();
    int n;
    s5 = 1'b0; d5 = 11'd13; v5 = 1'b1;
    @(posedge clk); #1 v5 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      d5 = 11'($urandom); s5 = ~s5;
      @(posedge clk); #1;
    end
    s5 = 1'b0;
    n = 0;
    while (!ov5 && n < 200) begin @(posedge clk); #1 n++; end
    total++; if (od5 !== 8'd3) $display("FAIL in_change_data got %0d want 3", od5); else pass_cnt++;
    total++; if (os5 !== 1'b0) $display("FAIL in_change_signed got %b want 0", os5); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int bad;
    int n;
    or5 = 1'b1; s5 = 1'b0; d5 = 11'd12; v5 = 1'b1;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if (ir5) acc.push_back(c);
      if (ov5 && od5 !== 8'd2) bad++;
      @(posedge clk); #1;
    end
    v5 = 1'b0;
    total++; if (acc.size() < 3) $display("FAIL b2b_count got %0d want >=3", acc.size()); else pass_cnt++;
    if (acc.size() >= 3) begin
      total++; if (acc[1] - acc[0] != 14) $display("FAIL b2b_gap1 got %0d want 14", acc[1] - acc[0]); else pass_cnt++;
      total++; if (acc[2] - acc[1] != 14) $display("FAIL b2b_gap2 got %0d want 14", acc[2] - acc[1]); else pass_cnt++;
    end
    total++; if (bad != 0) $display("FAIL b2b_data got %0d bad want 0", bad); else pass_cnt++;
    n = 0;
    while (!ir5 && n < 200) begin @(posedge clk); #1 n++; end
  endtask

  task automatic test_mid_reset();
    logic [7:0] r;
    int lat;
    int pulses;
    s5 = 1'b0; d5 = 11'd1275; v5 = 1'b1;
    @(posedge clk); #1 v5 = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++; if ({ov5, ir5, od5} !== {1'b0, 1'b1, 8'h00})
      $display("FAIL midrst_state got %b want 0_1_00000000", {ov5, ir5, od5}); else pass_cnt++;
    @(posedge clk); #1 reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (ov5) pulses++;
      @(posedge clk); #1;
    end
    total++; if (pulses != 0) $display("FAIL midrst_pulse got %0d want 0", pulses); else pass_cnt++;
    run5(1'b0, 11'd13, r, lat);
    total++; if (r !== 8'd3) $display("FAIL midrst_next got %0d want 3", r); else pass_cnt++;
  endtask

  initial begin
    s5 = 1'b0; d5 = '0; v5 = 1'b0; or5 = 1'b1;
    s4 = 1'b0; d4 = '0; v4 = 1'b0; or4 = 1'b1;
    test_reset();
    test_rounding();
    test_backpressure();
    test_input_change();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
